// File: rtl/tinynpu_pkg.sv
// Shared TinyNPU definitions: NPU mode codes, result-buffer FSM states, word geometry.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package tinynpu_pkg;

    // Each stored result word holds four operand-widths, leaving headroom for accumulation
    localparam int WORD_MULT = 4;

    // Width of depth, pointer, count and read-address fields
    localparam int ADDR_W = 12;

    // NPU operating modes
    typedef enum logic [1:0] {
        MODE_CONV   = 2'd0,
        MODE_FC     = 2'd1,
        MODE_POOL   = 2'd2,
        MODE_BYPASS = 2'd3
    } npu_mode_e;

    // Result buffer FSM encodings (visible on o_state)
    typedef enum logic [1:0] {
        RB_IDLE  = 2'd0,
        RB_FILL  = 2'd1,
        RB_ACCUM = 2'd2,
        RB_DONE  = 2'd3
    } rb_state_e;

    // Stored word width for a given operand width
    function automatic int word_width(input int data_size);
        return data_size * WORD_MULT;
    endfunction

endpackage

// File: rtl/result_ram.sv
// Result word store: one write port (overwrite or add-to-stored) and one registered read port.
// Latency: write takes effect at the clock edge; read data and valid appear one cycle after the request.
// Backpressure: none; always accepts. A same-cycle read of the written address returns the old word.
module result_ram
    import tinynpu_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 27
) (
    input  logic              i_clk,
    input  logic              i_n_reset,
    input  logic              i_clr,
    input  logic              i_wr_en,
    input  logic              i_wr_acc,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [W-1:0]      i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [W-1:0]      o_rd_data,
    output logic              o_rd_valid
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_C = ADDR_W'(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rd_data_q;
    logic         rd_valid_q;
    logic         wr_in_range;
    logic         rd_in_range;

    // Address range qualification for both ports
    always_comb begin
        wr_in_range = (i_wr_addr < DEPTH_C);
        rd_in_range = (i_rd_addr < DEPTH_C);
    end

    // Storage: reset/clear zero everything; a write either overwrites or accumulates (wrapping add)
    always_ff @(posedge i_clk) begin
        if (!i_n_reset || i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (i_wr_en && wr_in_range) begin
            if (i_wr_acc) begin
                mem_q[i_wr_addr[AW-1:0]] <= mem_q[i_wr_addr[AW-1:0]] + i_wr_data;
            end else begin
                mem_q[i_wr_addr[AW-1:0]] <= i_wr_data;
            end
        end
    end

    // Registered read port; addresses past the end read as zero
    always_ff @(posedge i_clk) begin
        if (!i_n_reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= i_rd_en;
            if (i_rd_en) begin
                rd_data_q <= rd_in_range ? mem_q[i_rd_addr[AW-1:0]] : '0;
            end
        end
    end

    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;

endmodule

// File: rtl/result_buffer.sv
// Result buffer: collects NPU result words per pass (overwrite or accumulate), host-readable; optional ReLU via RESULT_BUFFER_RELU_EN.
// Latency: writes land at the clock edge; reads return one cycle after i_rd_req; o_pass_done one cycle after the last word of a pass.
// Backpressure: none; every cycle accepts a write and a read. Out-of-range or misconfigured writes are dropped and flag o_overflow.
module result_buffer
    import tinynpu_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int RAM_DEPTH = 27
) (
    input  logic                              i_clk,
    input  logic                              i_n_reset,
    input  logic                              i_rst_buf,
    input  logic                              i_wr,
    input  logic                              i_valid,
    input  logic signed [DATA_SIZE*WORD_MULT-1:0] i_data,
    input  logic                              i_accumulate,
    input  logic                              i_output_layer,
    input  logic [ADDR_W-1:0]                 i_output_depth,
    input  logic                              i_rd_req,
    input  logic [ADDR_W-1:0]                 i_rd_addr,
    output logic [DATA_SIZE*WORD_MULT-1:0]    o_rd_data,
    output logic                              o_rd_valid,
    output logic [ADDR_W-1:0]                 o_count,
    output logic                              o_pass_done,
    output logic                              o_full,
    output logic                              o_overflow,
    output logic [1:0]                        o_state
);

    localparam int W = word_width(DATA_SIZE);
    localparam logic [ADDR_W-1:0] DEPTH_C = ADDR_W'(RAM_DEPTH);

    rb_state_e         state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic              pass_done_q;
    logic              full_q;
    logic              ovf_q;

    logic              acc_wr;
    logic              cfg_err;
    logic              ptr_oob;
    logic              wr_ok;
    logic              wr_drop;
    logic              last_word;
    logic              pass_end;

    logic [W-1:0]      ram_rd_data;

    // Write qualification and next pointer. A bad depth freezes the pointer so
    // nothing lands until the host fixes the configuration.
    always_comb begin
        acc_wr    = i_wr & i_valid;
        cfg_err   = (i_output_depth == '0) || (i_output_depth > DEPTH_C);
        ptr_oob   = (ptr_q >= DEPTH_C);
        wr_drop   = acc_wr & (cfg_err | ptr_oob);
        wr_ok     = acc_wr & ~cfg_err & ~ptr_oob & ~i_rst_buf;
        // >= rather than == so a depth lowered mid-pass still closes the pass
        last_word = (ptr_q >= (i_output_depth - 12'd1));
        pass_end  = wr_ok & last_word;
        ptr_d     = ptr_q;
        if (wr_ok) begin
            ptr_d = last_word ? '0 : (ptr_q + 12'd1);
        end
    end

    // Pass-tracking FSM with its registered status outputs; buffer clear acts like reset
    always_ff @(posedge i_clk) begin
        if (!i_n_reset || i_rst_buf) begin
            state_q     <= RB_IDLE;
            ptr_q       <= '0;
            pass_done_q <= 1'b0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            pass_done_q <= pass_end;
            if (pass_end) begin
                full_q <= 1'b1;
            end
            if (wr_drop) begin
                ovf_q <= 1'b1;
            end
            if (wr_ok) begin
                if (last_word) begin
                    state_q <= RB_DONE;
                end else begin
                    case (state_q)
                        RB_IDLE: state_q <= RB_FILL;
                        RB_DONE: state_q <= i_accumulate ? RB_ACCUM : RB_FILL;
                        default: state_q <= state_q;
                    endcase
                end
            end
        end
    end

    result_ram #(
        .W     (W),
        .DEPTH (RAM_DEPTH)
    ) u_ram (
        .i_clk      (i_clk),
        .i_n_reset  (i_n_reset),
        .i_clr      (i_rst_buf),
        .i_wr_en    (wr_ok),
        .i_wr_acc   (i_accumulate),
        .i_wr_addr  (ptr_q),
        .i_wr_data  (i_data),
        .i_rd_en    (i_rd_req),
        .i_rd_addr  (i_rd_addr),
        .o_rd_data  (ram_rd_data),
        .o_rd_valid (o_rd_valid)
    );

`ifdef RESULT_BUFFER_RELU_EN
    logic out_layer_q;

    // Capture the layer kind with the request so the clamp matches the word being returned
    always_ff @(posedge i_clk) begin
        if (!i_n_reset) begin
            out_layer_q <= 1'b0;
        end else if (i_rd_req) begin
            out_layer_q <= i_output_layer;
        end
    end

    // Clamp only on the way out; stored words stay exact for later accumulation
    assign o_rd_data = (ram_rd_data[W-1] && !out_layer_q) ? '0 : ram_rd_data;
`else
    logic unused_output_layer;
    assign unused_output_layer = i_output_layer;
    assign o_rd_data = ram_rd_data;
`endif

    assign o_count     = ptr_q;
    assign o_pass_done = pass_done_q;
    assign o_full      = full_q;
    assign o_overflow  = ovf_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_result_buffer.sv
// Bench for result_buffer: directed writes/reads, read responses checked by a scoreboard monitor.
// Latency: reads expected one cycle after request; status sampled #1 after the clock edge.
// Backpressure: none on the DUT; the bench drives one transaction per cycle.
module tb_result_buffer;

    logic        i_clk = 1'b0;
    logic        i_n_reset;
    logic        i_rst_buf;
    logic        i_wr;
    logic        i_valid;
    logic [31:0] i_data;
    logic        i_accumulate;
    logic        i_output_layer;
    logic [11:0] i_output_depth;
    logic        i_rd_req;
    logic [11:0] i_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_rd_valid;
    logic [11:0] o_count;
    logic        o_pass_done;
    logic        o_full;
    logic        o_overflow;
    logic [1:0]  o_state;

    always #5 i_clk = ~i_clk;

    result_buffer #(
        .DATA_SIZE (8),
        .RAM_DEPTH (27)
    ) dut (
        .i_clk          (i_clk),
        .i_n_reset      (i_n_reset),
        .i_rst_buf      (i_rst_buf),
        .i_wr           (i_wr),
        .i_valid        (i_valid),
        .i_data         (i_data),
        .i_accumulate   (i_accumulate),
        .i_output_layer (i_output_layer),
        .i_output_depth (i_output_depth),
        .i_rd_req       (i_rd_req),
        .i_rd_addr      (i_rd_addr),
        .o_rd_data      (o_rd_data),
        .o_rd_valid     (o_rd_valid),
        .o_count        (o_count),
        .o_pass_done    (o_pass_done),
        .o_full         (o_full),
        .o_overflow     (o_overflow),
        .o_state        (o_state)
    );

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t sb_q[$];
    int      n_vec  = 0;
    int      n_err  = 0;
    int      pd_cnt = 0;

    localparam logic [31:0] NEG5 = 32'hFFFF_FFFB;

    // Monitor: count pass_done pulses and check each read response against the scoreboard
    always @(negedge i_clk) begin
        rd_exp_t e;
        if (o_pass_done === 1'b1) pd_cnt++;
        if (o_rd_valid === 1'b1) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: got response data 0x%h, required no response", o_rd_data);
            end else begin
                e = sb_q.pop_front();
                if (o_rd_data !== e.data) begin
                    n_err++;
                    $display("FAIL rd_data[%0d]: got 0x%h, required 0x%h", e.addr, o_rd_data, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
        end
    endtask

    // One clock of stimulus: optional write (wr/valid separate) and optional read with its expected data
    task automatic cyc(input logic wr, input logic vld, input logic [31:0] d, input logic acc,
                       input logic rd, input logic [11:0] a, input logic [31:0] exp);
        rd_exp_t e;
        i_wr = wr; i_valid = vld; i_data = d; i_accumulate = acc;
        i_rd_req = rd; i_rd_addr = a;
        if (rd) begin
            e.addr = a; e.data = exp;
            sb_q.push_back(e);
        end
        @(posedge i_clk); #1;
        i_wr = 1'b0; i_valid = 1'b0; i_rd_req = 1'b0;
    endtask

    task automatic wr(input logic [31:0] d, input logic acc);
        cyc(1'b1, 1'b1, d, acc, 1'b0, 12'd0, 32'd0);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, a, exp);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk); #1;
        end
    endtask

    task automatic clr();
        i_rst_buf = 1'b1;
        @(posedge i_clk); #1;
        i_rst_buf = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        i_n_reset = 1'b0; i_rst_buf = 1'b0; i_wr = 1'b0; i_valid = 1'b0; i_data = '0;
        i_accumulate = 1'b0; i_output_layer = 1'b0; i_output_depth = 12'd9;
        i_rd_req = 1'b0; i_rd_addr = '0;
        idle(3);
        chk("reset_state", o_state, 0);
        chk("reset_count", o_count, 0);
        chk("reset_full", o_full, 0);
        chk("reset_ovf", o_overflow, 0);
        chk("reset_rd_valid", o_rd_valid, 0);
        chk("reset_pass_done", o_pass_done, 0);
        i_n_reset = 1'b1;
        idle(1);

        // valid without write enable is not an accepted write
        cyc(1'b0, 1'b1, 32'd55, 1'b0, 1'b0, 12'd0, 32'd0);
        chk("vld_only_count", o_count, 0);
        chk("vld_only_state", o_state, 0);

        // Pass 1: depth 9, words 1..9 overwrite
        for (int i = 1; i <= 8; i++) wr(i, 1'b0);
        chk("p1_state_fill", o_state, 1);
        chk("p1_count8", o_count, 8);
        chk("p1_no_pd_yet", o_pass_done, 0);
        wr(9, 1'b0);
        chk("p1_pass_done", o_pass_done, 1);
        chk("p1_state_done", o_state, 3);
        chk("p1_full", o_full, 1);
        chk("p1_count_wrap", o_count, 0);
        idle(1);
        chk("p1_pd_one_cycle", o_pass_done, 0);
        for (int i = 0; i < 9; i++) rd(i, i + 1);

        // Pass 2: accumulate 10 onto each word
        wr(10, 1'b1);
        chk("p2_state_accum", o_state, 2);
        for (int i = 1; i < 9; i++) wr(10, 1'b1);
        chk("p2_state_done", o_state, 3);
        chk("p2_full_held", o_full, 1);
        for (int i = 0; i < 9; i++) rd(i, i + 11);
        idle(1);
        chk("p2_pd_cnt", pd_cnt, 2);

        // Same-cycle read/write at address 3: old 7, new 20
        for (int i = 0; i < 9; i++) wr((i == 3) ? 32'd7 : 32'd0, 1'b0);
        wr(0, 1'b0);
        chk("rw_state_fill", o_state, 1);
        wr(0, 1'b0);
        wr(0, 1'b0);
        cyc(1'b1, 1'b1, 32'd20, 1'b0, 1'b1, 12'd3, 32'd7);
        rd(3, 20);
        chk("rw_count4", o_count, 4);

        // Buffer clear with a simultaneous write after 4 words
        i_rst_buf = 1'b1;
        wr(99, 1'b0);
        i_rst_buf = 1'b0;
        chk("clr_count", o_count, 0);
        chk("clr_state", o_state, 0);
        chk("clr_full", o_full, 0);
        chk("clr_no_pd", o_pass_done, 0);
        rd(0, 0);
        rd(3, 0);
        rd(8, 0);
        idle(2);
        chk("clr_pd_cnt", pd_cnt, 3);

        // ReLU on readout: -5 at address 0
        wr(NEG5, 1'b0);
        i_output_layer = 1'b0;
`ifdef RESULT_BUFFER_RELU_EN
        rd(0, 0);
`else
        rd(0, NEG5);
`endif
        i_output_layer = 1'b1;
        rd(0, NEG5);
        i_output_layer = 1'b0;

        // Depth 0 is a configuration error
        clr();
        i_output_depth = 12'd0;
        wr(1, 1'b0);
        chk("d0_ovf", o_overflow, 1);
        chk("d0_state", o_state, 0);
        chk("d0_count", o_count, 0);
        clr();
        chk("d0_ovf_cleared", o_overflow, 0);

        // Fill all 27 words, then depth 30 exceeds the RAM: writes dropped, contents intact
        i_output_depth = 12'd27;
        for (int i = 0; i < 27; i++) wr(100 + i, 1'b0);
        chk("d27_full", o_full, 1);
        chk("d27_ovf", o_overflow, 0);
        chk("d27_state", o_state, 3);
        i_output_depth = 12'd30;
        for (int i = 0; i < 30; i++) wr(500, 1'b0);
        chk("d30_ovf", o_overflow, 1);
        chk("d30_count", o_count, 0);
        chk("d30_state", o_state, 3);
        for (int i = 0; i < 27; i++) rd(i, 100 + i);
        rd(27, 0);
        rd(12'hFFF, 0);
        idle(1);
        chk("d30_pd_cnt", pd_cnt, 4);

        // Reset mid-pass discards the partial pass
        clr();
        i_output_depth = 12'd9;
        for (int i = 0; i < 3; i++) wr(5, 1'b0);
        chk("mid_count3", o_count, 3);
        i_n_reset = 1'b0;
        idle(1);
        chk("mid_rst_state", o_state, 0);
        chk("mid_rst_count", o_count, 0);
        chk("mid_rst_pd", o_pass_done, 0);
        chk("mid_rst_rd_valid", o_rd_valid, 0);
        i_n_reset = 1'b1;
        rd(0, 0);
        idle(3);
        chk("mid_pd_cnt", pd_cnt, 4);
        chk("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
